sine_voice_scheduler: RTL and testbench

- Time-shares one quarter-wave sine table among VOICES phase accumulators (polyphonic DDS).
- On each sample tick, steps every voice's phase, folds it into the table's angle/quadrant form, issues one lookup per cycle, sign-corrects the returned values and sums them into one mixed sample.
- Sits between the note-to-adder logic (which supplies cfg_adder) and the shared sinetable instance.

---
 rtl/sine_voice_scheduler.sv | 236 +++++++++++++++++++++++
 tb/tb_sine_voice_scheduler.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sine_voice_scheduler.sv
// sine_voice_scheduler: time-shares one quarter-wave sine table among VOICES
// DDS phase accumulators. Each sample tick steps every voice, issues one
// folded table lookup per cycle, sign-corrects the returns and sums them
// into one signed mixed sample.
// Optional per-voice attenuation (arithmetic right shift of each voice
// sample) is built when SINE_SCHED_ATTEN_EN is defined.
//
// Table handshake: tab_req is a valid with no ready; the table accepts
// every request, and the matching tab_sample is valid exactly TAB_LAT
// cycles after the cycle in which tab_req was high.
module sine_voice_scheduler #(
    parameter int  VOICES  = 8,
    parameter int  PHASE_W = 32,
    parameter int  N       = 7,
    parameter int  TAB_LAT = 2,
    localparam int VW      = $clog2(VOICES),
    localparam int MIX_W   = N + 2 + VW
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               sample_tick,
    input  logic               cfg_we,
    input  logic [VW-1:0]      cfg_voice,
    input  logic [PHASE_W-1:0] cfg_adder,
    input  logic               cfg_en,
    input  logic               cfg_sync,
`ifdef SINE_SCHED_ATTEN_EN
    input  logic [2:0]         cfg_atten,
`endif
    output logic               tab_req,
    output logic [N-1:0]       tab_angle,
    output logic [1:0]         tab_quadrant,
    input  logic [N:0]         tab_sample,
    output logic [MIX_W-1:0]   mix_out,
    output logic               sample_valid,
    output logic               busy,
    output logic               overrun,
    output logic [1:0]         dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [VW-1:0]      vidx_q, vidx_d;
    logic [1:0]         dcnt_q, dcnt_d;
    logic [MIX_W-1:0]   acc_q, acc_d;
    logic [MIX_W-1:0]   mix_q, mix_d;
    logic               overrun_q, overrun_d;

    logic [PHASE_W-1:0] phase_q [VOICES];
    logic [PHASE_W-1:0] phase_d [VOICES];
    logic [PHASE_W-1:0] adder_q [VOICES];
    logic [VOICES-1:0]  en_q;

    // Return pipeline: marks which cycles carry a valid table return and
    // the quadrant that decides its sign.
    logic [TAB_LAT-1:0] pv_q;
    logic [1:0]         pq_q [TAB_LAT];

`ifdef SINE_SCHED_ATTEN_EN
    logic [2:0]         atten_q [VOICES];
    logic [2:0]         pa_q [TAB_LAT];
`endif

    logic [1:0]         cur_quad;
    logic [N-1:0]       cur_angle;
    logic [MIX_W-1:0]   mag_ext;
    logic signed [MIX_W-1:0] contrib;

    assign cur_quad  = phase_q[vidx_q][PHASE_W-1 -: 2];
    assign cur_angle = phase_q[vidx_q][PHASE_W-3 -: N];

    // Frame sequencing and lookup issue; the pre-advance phase drives the table.
    always_comb begin
        state_d      = state_q;
        vidx_d       = vidx_q;
        dcnt_d       = dcnt_q;
        tab_req      = 1'b0;
        tab_angle    = '0;
        tab_quadrant = '0;
        sample_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sample_tick) begin
                    state_d = S_ISSUE;
                    vidx_d  = '0;
                end
            end
            S_ISSUE: begin
                tab_req = en_q[vidx_q];
                if (en_q[vidx_q]) begin
                    tab_quadrant = cur_quad;
                    // Odd quadrants read the quarter wave backwards.
                    tab_angle    = cur_quad[0] ? ~cur_angle : cur_angle;
                end
                vidx_d = vidx_q + VW'(1);
                if (vidx_q == VW'(VOICES - 1)) begin
                    state_d = S_DRAIN;
                    dcnt_d  = '0;
                end
            end
            S_DRAIN: begin
                dcnt_d = dcnt_q + 2'd1;
                if (dcnt_q == 2'(TAB_LAT - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                sample_valid = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sign-correct each returned magnitude and accumulate; latch the finished
    // sum into mix_q on the edge that enters DONE.
    always_comb begin
        mag_ext = {{(MIX_W - N - 1){1'b0}}, tab_sample};
        contrib = pq_q[TAB_LAT-1][1] ? -mag_ext : mag_ext;
`ifdef SINE_SCHED_ATTEN_EN
        contrib = contrib >>> pa_q[TAB_LAT-1];
`endif
        acc_d = acc_q;
        if (state_q == S_IDLE && sample_tick) begin
            acc_d = '0;
        end else if (pv_q[TAB_LAT-1]) begin
            acc_d = acc_q + contrib;
        end
        mix_d = mix_q;
        if (state_q == S_DRAIN && dcnt_q == 2'(TAB_LAT - 1)) begin
            mix_d = acc_d;
        end
        overrun_d = overrun_q | (sample_tick && state_q != S_IDLE);
    end

    // Phase next-state: a sync write beats the voice's own advance.
    always_comb begin
        for (int i = 0; i < VOICES; i++) begin
            phase_d[i] = phase_q[i];
            if (cfg_we && cfg_sync && cfg_voice == VW'(i)) begin
                phase_d[i] = '0;
            end else if (state_q == S_ISSUE && vidx_q == VW'(i) && en_q[i]) begin
                phase_d[i] = phase_q[i] + adder_q[i];
            end
        end
    end

    // FSM, accumulator, mix and sticky overrun registers.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q   <= S_IDLE;
            vidx_q    <= '0;
            dcnt_q    <= '0;
            acc_q     <= '0;
            mix_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vidx_q    <= vidx_d;
            dcnt_q    <= dcnt_d;
            acc_q     <= acc_d;
            mix_q     <= mix_d;
            overrun_q <= overrun_d;
        end
    end

    // Phase accumulators.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int i = 0; i < VOICES; i++) begin
                phase_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < VOICES; i++) begin
                phase_q[i] <= phase_d[i];
            end
        end
    end

    // Voice configuration; accepted in any state, effective from the next cycle.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int i = 0; i < VOICES; i++) begin
                adder_q[i] <= '0;
`ifdef SINE_SCHED_ATTEN_EN
                atten_q[i] <= '0;
`endif
            end
            en_q <= '0;
        end else if (cfg_we) begin
            adder_q[cfg_voice] <= cfg_adder;
            en_q[cfg_voice]    <= cfg_en;
`ifdef SINE_SCHED_ATTEN_EN
            atten_q[cfg_voice] <= cfg_atten;
`endif
        end
    end

    // Return pipeline tracking requests in flight; reset drops them all.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            pv_q <= '0;
            for (int k = 0; k < TAB_LAT; k++) begin
                pq_q[k] <= '0;
`ifdef SINE_SCHED_ATTEN_EN
                pa_q[k] <= '0;
`endif
            end
        end else begin
            pv_q[0] <= tab_req;
            pq_q[0] <= tab_quadrant;
`ifdef SINE_SCHED_ATTEN_EN
            pa_q[0] <= atten_q[vidx_q];
`endif
            for (int k = 1; k < TAB_LAT; k++) begin
                pv_q[k] <= pv_q[k-1];
                pq_q[k] <= pq_q[k-1];
`ifdef SINE_SCHED_ATTEN_EN
                pa_q[k] <= pa_q[k-1];
`endif
            end
        end
    end

    assign mix_out     = mix_q;
    assign busy        = (state_q != S_IDLE);
    assign overrun     = overrun_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sine_voice_scheduler.sv
// Bench for sine_voice_scheduler: a table model, a reference mixer working
// from the sine-fold rules, and a monitor that checks every lookup request
// and every mixed sample (value and arrival cycle) against queued expectations.
module tb_sine_voice_scheduler;

    localparam int VOICES    = 8;
    localparam int TAB_LAT   = 2;
    localparam int VW        = 3;
    localparam int MIX_W     = 12;
    localparam int FRAME_LAT = VOICES + TAB_LAT + 1;

    logic             CLK = 1'b0;
    logic             RESET = 1'b0;
    logic             sample_tick = 1'b0;
    logic             cfg_we = 1'b0;
    logic [VW-1:0]    cfg_voice = '0;
    logic [31:0]      cfg_adder = '0;
    logic             cfg_en = 1'b0;
    logic             cfg_sync = 1'b0;
    logic             tab_req;
    logic [6:0]       tab_angle;
    logic [1:0]       tab_quadrant;
    logic [7:0]       tab_sample;
    logic [MIX_W-1:0] mix_out;
    logic             sample_valid;
    logic             busy;
    logic             overrun;
    logic [1:0]       dbg_state;

    sine_voice_scheduler dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .sample_tick  (sample_tick),
        .cfg_we       (cfg_we),
        .cfg_voice    (cfg_voice),
        .cfg_adder    (cfg_adder),
        .cfg_en       (cfg_en),
        .cfg_sync     (cfg_sync),
        .tab_req      (tab_req),
        .tab_angle    (tab_angle),
        .tab_quadrant (tab_quadrant),
        .tab_sample   (tab_sample),
        .mix_out      (mix_out),
        .sample_valid (sample_valid),
        .busy         (busy),
        .overrun      (overrun),
        .dbg_state_o  (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- table model: {0, angle} after two cycles ----------------
    logic [7:0] tab_d1, tab_d2;
    always @(posedge CLK) begin
        tab_d1 <= {1'b0, tab_angle};
        tab_d2 <= tab_d1;
    end
    assign tab_sample = tab_d2;

    // ---------------- scoreboard state ----------------
    logic [MIX_W-1:0] exp_q[$];
    logic [8:0]       req_q[$];
    int               lat_q[$];
    int               n_vec = 0;
    int               n_err = 0;

    logic [31:0] ph_m  [VOICES];
    logic [31:0] add_m [VOICES];
    bit          en_m  [VOICES];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference mixer: each enabled voice contributes a quarter-wave read,
    // mirrored in odd quadrants and negated in the lower half of the cycle.
    task automatic model_frame();
        int         sum;
        logic [1:0] q;
        logic [6:0] a;
        logic [6:0] ang;
        sum = 0;
        for (int i = 0; i < VOICES; i++) begin
            if (en_m[i]) begin
                q   = ph_m[i][31:30];
                a   = ph_m[i][29:23];
                ang = q[0] ? 7'(127 - int'(a)) : a;
                req_q.push_back({q, ang});
                sum = (q >= 2'd2) ? sum - int'(ang) : sum + int'(ang);
                ph_m[i] = ph_m[i] + add_m[i];
            end
        end
        exp_q.push_back(MIX_W'(sum));
        lat_q.push_back(cyc + FRAME_LAT);
    endtask

    task automatic model_reset();
        for (int i = 0; i < VOICES; i++) begin
            ph_m[i]  = '0;
            add_m[i] = '0;
            en_m[i]  = 1'b0;
        end
        exp_q.delete();
        req_q.delete();
        lat_q.delete();
    endtask

    // ---------------- monitor ----------------
    always @(negedge CLK) begin
        if (RESET) begin
            if (tab_req) begin
                if (req_q.size() == 0) chk("unexpected tab_req", 32'd1, 32'd0);
                else chk("tab_req {quadrant,angle}", {23'd0, tab_quadrant, tab_angle}, {23'd0, req_q.pop_front()});
            end
            if (sample_valid) begin
                if (exp_q.size() == 0) chk("unexpected sample_valid", 32'd1, 32'd0);
                else begin
                    chk("mix_out", {20'd0, mix_out}, {20'd0, exp_q.pop_front()});
                    chk("sample_valid cycle", cyc, lat_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET       = 1'b0;
        sample_tick = 1'b0;
        cfg_we      = 1'b0;
        step();
        step();
        model_reset();
        RESET = 1'b1;
    endtask

    task automatic cfg_write(input logic [VW-1:0] v, input logic [31:0] add, input bit en, input bit sync);
        cfg_we    = 1'b1;
        cfg_voice = v;
        cfg_adder = add;
        cfg_en    = en;
        cfg_sync  = sync;
        step();
        cfg_we   = 1'b0;
        cfg_sync = 1'b0;
        add_m[v] = add;
        en_m[v]  = en;
        if (sync) ph_m[v] = '0;
    endtask

    task automatic pulse_tick(input bit counted);
        sample_tick = 1'b1;
        if (counted) model_frame();
        step();
        sample_tick = 1'b0;
    endtask

    task automatic wait_idle();
        repeat (FRAME_LAT + 2) step();
        chk("busy after frame", {31'd0, busy}, 32'd0);
        chk("frame drained", exp_q.size() + req_q.size(), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset values while RESET is held low.
        RESET = 1'b0;
        step();
        step();
        chk("reset mix_out", {20'd0, mix_out}, 32'd0);
        chk("reset sample_valid", {31'd0, sample_valid}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset overrun", {31'd0, overrun}, 32'd0);
        chk("reset tab_req", {31'd0, tab_req}, 32'd0);
        model_reset();
        RESET = 1'b1;
        step();
        pulse_tick(1'b1);
        chk("busy during frame", {31'd0, busy}, 32'd1);
        wait_idle();
        chk("first frame mix", {20'd0, mix_out}, 32'd0);

        // Quadrant fold: one voice stepping a quarter cycle per frame.
        cfg_write(3'd0, 32'h4000_0000, 1'b1, 1'b1);
        pulse_tick(1'b1); wait_idle();
        chk("quadrant 0 mix", {20'd0, mix_out}, 32'd0);
        pulse_tick(1'b1); wait_idle();
        chk("quadrant 1 mix", {20'd0, mix_out}, 32'd127);
        pulse_tick(1'b1); wait_idle();
        chk("quadrant 2 mix", {20'd0, mix_out}, 32'd0);
        pulse_tick(1'b1); wait_idle();
        chk("quadrant 3 mix", {20'd0, mix_out}, 32'h0000_0F81);

        // Latency and sum with all voices enabled.
        do_reset();
        for (int v = 0; v < VOICES; v++) cfg_write(VW'(v), 32'h0200_0000, 1'b1, 1'b0);
        pulse_tick(1'b1); wait_idle();
        pulse_tick(1'b1); wait_idle();
        chk("eight voices sum", {20'd0, mix_out}, 32'd32);

        // Overrun: tick at t+5 is ignored, overrun sticks.
        chk("overrun before", {31'd0, overrun}, 32'd0);
        pulse_tick(1'b1);
        repeat (4) step();
        pulse_tick(1'b0);
        wait_idle();
        chk("overrun after busy tick", {31'd0, overrun}, 32'd1);
        // Tick landing in the DONE cycle is also ignored.
        pulse_tick(1'b1);
        repeat (FRAME_LAT - 1) step();
        pulse_tick(1'b0);
        wait_idle();
        pulse_tick(1'b1); wait_idle();
        chk("overrun sticky", {31'd0, overrun}, 32'd1);

        // Reset in the middle of a frame.
        do_reset();
        chk("overrun cleared by reset", {31'd0, overrun}, 32'd0);
        for (int v = 0; v < 4; v++) cfg_write(VW'(v), $urandom, 1'b1, 1'b0);
        pulse_tick(1'b1);
        repeat (3) step();
        RESET = 1'b0;
        step();
        model_reset();
        RESET = 1'b1;
        chk("busy after mid-frame reset", {31'd0, busy}, 32'd0);
        repeat (FRAME_LAT + 2) step();
        pulse_tick(1'b1); wait_idle();
        chk("mix after mid-frame reset", {20'd0, mix_out}, 32'd0);

        // Config collision in voice 3's own issue cycle.
        do_reset();
        cfg_write(3'd3, 32'h4000_0000, 1'b1, 1'b0);
        cfg_write(3'd0, $urandom, 1'b1, 1'b0);
        pulse_tick(1'b1); wait_idle();
        pulse_tick(1'b1);
        repeat (3) step();
        cfg_write(3'd3, 32'h0800_0000, 1'b1, 1'b1);
        wait_idle();
        pulse_tick(1'b1); wait_idle();
        pulse_tick(1'b1); wait_idle();

        // Randomized configurations and frames.
        do_reset();
        for (int f = 0; f < 24; f++) begin
            int nw;
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++) begin
                cfg_write(VW'($urandom_range(0, VOICES - 1)), $urandom,
                          $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0);
            end
            pulse_tick(1'b1);
            wait_idle();
        end

        chk("final queues empty", exp_q.size() + req_q.size() + lat_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
